// File: rtl/riscv_wb_arbiter_pkg.sv
// riscv_wb_pkg: shared types and constants for the writeback arbiter
//   wb_entry_t : one queued register-file write {waddr, wdata}
//   wb_src_e   : round-robin source identifiers (LSU, MUL/DIV)
//   WB_X0      : the hard-wired zero register; writes to it are dropped
package riscv_wb_pkg;
  localparam int WB_ADDR_WIDTH = 6;
  localparam int WB_DATA_WIDTH = 32;
  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] waddr;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } wb_entry_t;
  typedef enum logic {WB_SRC_LSU = 1'b0, WB_SRC_MUL = 1'b1} wb_src_e;
  localparam logic [WB_ADDR_WIDTH-1:0] WB_X0 = '0;
endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// riscv_wb_arbiter_if: writeback bus between the result producers and the register file
//   alu_*      : ALU result, always accepted, drives port A
//   lsu_*/mul_*: valid/ready result sources, arbitrated into the port-B queue
//   *_a_o/*_b_o: register-file write ports A and B
//   pending_o  : one bit per register with a queued write; full_o: queue full
//   coll_cnt_o/stall_cnt_o only exist when RISCV_WB_PERF_EN is defined
//   modport slave: the arbiter; modport master: the core side driving the sources
interface riscv_wb_arbiter_if
  import riscv_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
);
  logic                     alu_we_i;
  logic [ADDR_WIDTH-1:0]    alu_waddr_i;
  logic [DATA_WIDTH-1:0]    alu_wdata_i;
  logic                     lsu_valid_i;
  logic                     lsu_ready_o;
  logic [ADDR_WIDTH-1:0]    lsu_waddr_i;
  logic [DATA_WIDTH-1:0]    lsu_wdata_i;
  logic                     mul_valid_i;
  logic                     mul_ready_o;
  logic [ADDR_WIDTH-1:0]    mul_waddr_i;
  logic [DATA_WIDTH-1:0]    mul_wdata_i;
  logic                     we_a_o;
  logic [ADDR_WIDTH-1:0]    waddr_a_o;
  logic [DATA_WIDTH-1:0]    wdata_a_o;
  logic                     we_b_o;
  logic [ADDR_WIDTH-1:0]    waddr_b_o;
  logic [DATA_WIDTH-1:0]    wdata_b_o;
  logic [2**ADDR_WIDTH-1:0] pending_o;
  logic                     full_o;
`ifdef RISCV_WB_PERF_EN
  logic [31:0]              coll_cnt_o;
  logic [31:0]              stall_cnt_o;
`endif
  modport slave (
    input  alu_we_i, alu_waddr_i, alu_wdata_i,
           lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
           mul_valid_i, mul_waddr_i, mul_wdata_i,
    output lsu_ready_o, mul_ready_o,
           we_a_o, waddr_a_o, wdata_a_o,
           we_b_o, waddr_b_o, wdata_b_o,
           pending_o, full_o
`ifdef RISCV_WB_PERF_EN
           , coll_cnt_o, stall_cnt_o
`endif
  );
  modport master (
    output alu_we_i, alu_waddr_i, alu_wdata_i,
           lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
           mul_valid_i, mul_waddr_i, mul_wdata_i,
    input  lsu_ready_o, mul_ready_o,
           we_a_o, waddr_a_o, wdata_a_o,
           we_b_o, waddr_b_o, wdata_b_o,
           pending_o, full_o
`ifdef RISCV_WB_PERF_EN
           , coll_cnt_o, stall_cnt_o
`endif
  );
endinterface

// File: rtl/riscv_wb_arbiter_fifo.sv
// riscv_wb_fifo: DEPTH-entry queue of register-file writes
//   clk_int, rst_n : clock, async active-low reset (contents discarded)
//   push/din       : enqueue one entry; pop: dequeue the head
//   head           : entry at the read pointer
//   mem_o/vld_o    : raw storage and per-slot valid bits, for the pending bitmap
//   full/empty     : occupancy flags
module riscv_wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk_int,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        head,
  output wb_entry_t        mem_o [DEPTH],
  output logic [DEPTH-1:0] vld_o,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [DEPTH-1:0] ONE = DEPTH'(1);
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;
  logic [DEPTH-1:0] vld;
  wb_entry_t     mem [DEPTH];
  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk_int or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wp] <= din;
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      vld <= (vld & ~({DEPTH{pop}} & (ONE << rp))) | ({DEPTH{push}} & (ONE << wp));
    end
  assign head  = mem[rp];
  assign mem_o = mem;
  assign vld_o = vld;
  assign full  = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: writeback arbiter for the two register-file write ports
//   clk_int : gated core clock
//   rst_n   : async active-low reset
//   bus     : riscv_wb_arbiter_if.slave (ALU/LSU/MUL sources, ports A/B, pending_o, full_o)
//   ALU results pass straight to port A; LSU and MUL/DIV are round-robin arbitrated
//   into a DEPTH-entry queue whose head drives port B.
//   Optional macro RISCV_WB_PERF_EN adds saturating collision and stall counters.
module riscv_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                clk_int,
  input logic                rst_n,
  riscv_wb_arbiter_if.slave  bus
);
  wb_src_e   prio;
  wb_entry_t head, sel;
  wb_entry_t fmem [DEPTH];
  logic [DEPTH-1:0] fvld;
  logic [2**WB_ADDR_WIDTH-1:0] pend;
  logic full, empty, gnt_lsu, gnt_mul, lsu_rdy, mul_rdy, acc, push, we_a, coll;
  assign we_a    = bus.alu_we_i & (bus.alu_waddr_i != WB_X0);
  assign gnt_lsu = bus.lsu_valid_i & (!bus.mul_valid_i | prio == WB_SRC_LSU);
  assign gnt_mul = bus.mul_valid_i & !gnt_lsu;
  // ready only looks at the registered count, and is held low while in reset
  assign lsu_rdy = gnt_lsu & !full & rst_n;
  assign mul_rdy = gnt_mul & !full & rst_n;
  assign acc     = lsu_rdy | mul_rdy;
  assign sel     = lsu_rdy ? '{waddr: bus.lsu_waddr_i, wdata: bus.lsu_wdata_i}
                           : '{waddr: bus.mul_waddr_i, wdata: bus.mul_wdata_i};
  // x0 beats are handshaken but never queued
  assign push    = acc & (sel.waddr != WB_X0);
  // the ALU write is always the newer one, so a matching head is discarded but still popped
  assign coll    = we_a & !empty & (head.waddr == bus.alu_waddr_i);
  // the pointer only moves when a contended grant is actually accepted
  always_ff @(posedge clk_int or negedge rst_n)
    if (!rst_n) prio <= WB_SRC_LSU;
    else if (bus.lsu_valid_i & bus.mul_valid_i & acc) prio <= prio == WB_SRC_LSU ? WB_SRC_MUL : WB_SRC_LSU;
  riscv_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_int (clk_int),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (!empty),
    .din     (sel),
    .head    (head),
    .mem_o   (fmem),
    .vld_o   (fvld),
    .full    (full),
    .empty   (empty)
  );
  // built purely from queue flops, so it changes on the edge after a push or pop
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) if (fvld[i]) pend[fmem[i].waddr] = 1'b1;
  end
  assign bus.lsu_ready_o = lsu_rdy;
  assign bus.mul_ready_o = mul_rdy;
  assign bus.we_a_o      = we_a;
  assign bus.waddr_a_o   = bus.alu_waddr_i;
  assign bus.wdata_a_o   = bus.alu_wdata_i;
  assign bus.we_b_o      = !empty & !coll;
  assign bus.waddr_b_o   = empty ? '0 : head.waddr;
  assign bus.wdata_b_o   = empty ? '0 : head.wdata;
  assign bus.pending_o   = pend;
  assign bus.full_o      = full;
`ifdef RISCV_WB_PERF_EN
  logic [31:0] coll_cnt, stall_cnt;
  logic stall;
  assign stall = (bus.lsu_valid_i & !lsu_rdy) | (bus.mul_valid_i & !mul_rdy);
  always_ff @(posedge clk_int or negedge rst_n)
    if (!rst_n) begin
      coll_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (coll && !(&coll_cnt)) coll_cnt <= coll_cnt + 32'd1;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
    end
  assign bus.coll_cnt_o  = coll_cnt;
  assign bus.stall_cnt_o = stall_cnt;
`endif
endmodule
